brpred_gshare: RTL
==================

Name: brpred_gshare

Overview:
- Gshare conditional-branch predictor. Serves the fetch/decode front end and produces the bptag/bptaken pair that decode writes into the ROB.
- Trained by the ROB retirement outputs (ret_branch, ret_bptag, ret_bptaken) and resynchronised by rob_flush.
- Holds a pattern history table (PHT) of 2-bit saturating counters, a speculative global history register (GHR) and an architectural GHR.

Parameters:
- IDX_BITS, 12, PHT index width; PHT has 2^IDX_BITS entries; legal range 4..16.
- GHR_BITS, 8, global history length; must be <= IDX_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- bp_ready  out  1  high once PHT initialisation is complete
- fetch_bp_valid  in  1  lookup request for a predecoded conditional branch
- fetch_bp_pc  in  30  [31:2] branch PC
- bp_valid  out  1  prediction valid (one cycle after the request)
- bp_taken  out  1  predicted direction
- bp_tag  out  16  PHT index, zero-extended; decode forwards it to the ROB
- rob_flush  in  1  pipeline flush
- rob_ret_branch  in  1  a conditional branch retired this cycle
- rob_ret_bptag  in  16  tag of the retiring branch
- rob_ret_bptaken  in  1  actual resolved direction

Behaviour:
- Async reset:
  - bp_ready=0, bp_valid=0, bp_taken=0, bp_tag=0.
  - Spec GHR=0, arch GHR=0, update stage idle, FSM=INIT, init counter=0.
- FSM INIT:
  - Writes 2'b01 (weakly not-taken) to PHT[init counter], one entry per cycle, counter +1.
  - After writing entry 2^IDX_BITS-1, moves to RUN.
  - bp_ready goes high the cycle after the last write.
  - In INIT, lookups are ignored (bp_valid stays 0) and retire updates are dropped.
  - rob_flush in INIT has no effect on the sweep.
- FSM RUN: no exit except reset.
- Index computation: idx = fetch_bp_pc[IDX_BITS+1:2] XOR zero-extended spec GHR.
- Lookup:
  - A request in cycle N registers bp_valid=1, bp_tag={0,idx} and bp_taken=PHT[idx][1] at edge N+1.
  - Latency is exactly 1 cycle; no back-pressure; one lookup per cycle.
  - A lookup in cycle N shifts bp_taken's value into spec GHR at edge N+1 (LSB in, MSB dropped).
  - bp_valid deasserts the cycle after any non-request cycle.
- Retire update:
  - rob_ret_branch in cycle N latches {tag[IDX_BITS-1:0], taken} into the update stage.
  - At edge N+1 the stage writes the saturated counter: +1 if taken (cap 3), -1 if not (floor 0).
  - Back-to-back updates to the same index forward the just-written value. No lost or stale increment.
  - Arch GHR shifts in rob_ret_bptaken at the edge ending cycle N.
- Read/write collision: a lookup and an update write to the same index in the same cycle return the old (pre-write) counter.
- Flush:
  - rob_flush in cycle N loads spec GHR with the arch GHR value after any same-cycle retire shift.
  - A lookup in cycle N is discarded: bp_valid=0 at N+1 and spec GHR is not shifted by it.
  - A bp_valid response already presented in cycle N is still output, but decode drops it.
  - Updates already latched complete normally.
- Simultaneous rob_ret_branch and rob_flush (mispredict): the PHT update proceeds and spec GHR includes the corrected outcome.
- Tag upper bits [15:IDX_BITS] are driven 0 and ignored on input.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds outputs bp_stat_branches[31:0] and bp_stat_mispred[31:0].
  - bp_stat_branches increments on each rob_ret_branch in RUN.
  - bp_stat_mispred increments when rob_ret_branch & rob_flush.
  - Both counters wrap at 2^32 and reset asynchronously to 0.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the tag width constant BPTAG_W=16;
  - 2-bit counter encodings (SNT=0, WNT=1, WT=2, ST=3) and the reset value WNT;
  - FSM state enum {INIT, RUN}.
- One sub-module, brpred_pht: a 2^IDX_BITS x 2 array with one read port, one write port and read-old-on-collision semantics.
- The FSM, GHRs and saturating arithmetic stay in brpred_gshare.

Test Plan:
1. Reset, IDX_BITS=4 -> bp_ready low for exactly 16 cycles, then high. Lookup at any PC -> bp_taken=0, bp_valid 1 cycle later.
2. pc=0x40, GHR=0 -> tag=0x0010. Retire that tag taken twice -> counter 3; next lookup bp_taken=1. Two further taken retires -> counter stays 3.
3. Back-to-back retires to tag 5 (taken, taken) starting at counter 1 -> counter 3 (forwarding). Same-cycle lookup of idx 5 during the first write -> returns 0.
4. Three lookups predicted 1,0,1 -> spec GHR=0b101. Then rob_flush with arch GHR=0b11 and a same-cycle retiring taken branch -> spec GHR=0b111. Lookup issued in the flush cycle -> bp_valid=0.
5. Assert rst mid-INIT at entry 7 -> outputs 0 immediately, sweep restarts from 0.
6. With BP_STATS_EN: 10 retires, 3 with rob_flush -> branches=10, mispred=3.

Source files
------------

// File: rtl/brpred_gshare_pkg.sv
// Shared definitions for the gshare branch predictor.
//   BPTAG_W    : width of the prediction tag carried through decode and the ROB
//   ctr_e      : 2-bit saturating counter encodings
//   CTR_RESET  : value written into every PHT entry by the init sweep
//   bp_state_e : controller states
//   ctr_sat    : saturating counter update
package brpred_gshare_pkg;

    localparam int BPTAG_W = 16;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam logic [1:0] CTR_RESET = WNT;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    function automatic logic [1:0] ctr_sat(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) res = ctr + 2'd1;
        end else begin
            if (ctr != SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/brpred_pht.sv
// Pattern history table: 2^IDX_BITS entries of 2-bit counters.
// Ports:
//   clk     in  clock
//   rd_idx  in  lookup index
//   rd_ctr  out counter at rd_idx (combinational; sees the pre-write value
//               when a write to the same index lands at the end of this cycle)
//   wr_en   in  write enable
//   wr_idx  in  write index
//   wr_ctr  in  value written at the clock edge
//   wr_old  out current counter at wr_idx, used for read-modify-write
// The array has no reset; the controller sweeps it after reset.
module brpred_pht #(
    parameter int IDX_BITS = 12
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [1:0]          wr_ctr,
    output logic [1:0]          wr_old
);

    logic [1:0] mem [2**IDX_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_ctr;
    end

    assign rd_ctr = mem[rd_idx];
    assign wr_old = mem[wr_idx];

endmodule

// File: rtl/brpred_gshare.sv
// Gshare conditional-branch predictor.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bp_ready            high once the PHT init sweep has finished
//   fetch_bp_valid/pc   lookup request, pc is the word address [31:2]
//   bp_valid/taken/tag  registered prediction, one cycle after the request
//   rob_flush           reload speculative history from architectural history
//   rob_ret_branch/bptag/bptaken  retiring branch used to train the PHT
// Optional feature (macro BP_STATS_EN): adds bp_stat_branches and
// bp_stat_mispred, 32-bit wrapping event counters.
//
// state | meaning
// INIT  | sweeping WNT into every PHT entry, lookups and retires ignored
// RUN   | predicting and training; left only by reset
module brpred_gshare
    import brpred_gshare_pkg::*;
#(
    parameter int IDX_BITS = 12,
    parameter int GHR_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               bp_ready,
    input  logic               fetch_bp_valid,
    input  logic [29:0]        fetch_bp_pc,
    output logic               bp_valid,
    output logic               bp_taken,
    output logic [BPTAG_W-1:0] bp_tag,
    input  logic               rob_flush,
    input  logic               rob_ret_branch,
    input  logic [BPTAG_W-1:0] rob_ret_bptag,
    input  logic               rob_ret_bptaken
`ifdef BP_STATS_EN
   ,output logic [31:0]        bp_stat_branches,
    output logic [31:0]        bp_stat_mispred
`endif
);

    bp_state_e state_q, state_d;
    logic [IDX_BITS-1:0] init_cnt_q;
    logic [GHR_BITS-1:0] spec_ghr_q, arch_ghr_q, arch_ghr_d;
    logic                upd_valid_q, upd_taken_q;
    logic [IDX_BITS-1:0] upd_idx_q;

    logic [IDX_BITS-1:0] lookup_idx;
    logic                running, lookup_go, retire_go;
    logic [1:0]          pht_rd_ctr, pht_wr_ctr, pht_wr_old;
    logic [IDX_BITS-1:0] pht_wr_idx;
    logic                pht_wr_en;

    assign running    = (state_q == RUN);
    assign bp_ready   = running;
    assign lookup_idx = fetch_bp_pc[IDX_BITS-1:0] ^ IDX_BITS'(spec_ghr_q);
    // A lookup in the flush cycle is discarded and must not touch spec history.
    assign lookup_go  = running & fetch_bp_valid & ~rob_flush;
    assign retire_go  = running & rob_ret_branch;
    // Flush reloads from this, so a mispredicting branch retiring in the
    // flush cycle is already part of the restored history.
    assign arch_ghr_d = retire_go ? GHR_BITS'({arch_ghr_q, rob_ret_bptaken}) : arch_ghr_q;

    assign pht_wr_idx = running ? upd_idx_q : init_cnt_q;
    assign pht_wr_ctr = running ? ctr_sat(pht_wr_old, upd_taken_q) : CTR_RESET;

    always_comb begin
        state_d   = state_q;
        pht_wr_en = 1'b0;
        unique case (state_q)
            INIT: begin
                pht_wr_en = 1'b1;
                if (init_cnt_q == '1) state_d = RUN;
            end
            RUN: pht_wr_en = upd_valid_q;
            default: state_d = INIT;
        endcase
    end

    brpred_pht #(.IDX_BITS(IDX_BITS)) u_pht (
        .clk    (clk),
        .rd_idx (lookup_idx),
        .rd_ctr (pht_rd_ctr),
        .wr_en  (pht_wr_en),
        .wr_idx (pht_wr_idx),
        .wr_ctr (pht_wr_ctr),
        .wr_old (pht_wr_old)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            spec_ghr_q  <= '0;
            arch_ghr_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
            bp_valid    <= 1'b0;
            bp_taken    <= 1'b0;
            bp_tag      <= '0;
        end else begin
            state_q <= state_d;
            if (!running) init_cnt_q <= init_cnt_q + 1'b1;

            // Writes land one cycle after latching; the next update to the
            // same index therefore reads the already-written counter.
            upd_valid_q <= retire_go;
            if (retire_go) begin
                upd_idx_q   <= rob_ret_bptag[IDX_BITS-1:0];
                upd_taken_q <= rob_ret_bptaken;
            end
            arch_ghr_q <= arch_ghr_d;

            bp_valid <= lookup_go;
            if (lookup_go) begin
                bp_tag   <= BPTAG_W'(lookup_idx);
                bp_taken <= pht_rd_ctr[1];
            end

            if (rob_flush)
                spec_ghr_q <= arch_ghr_d;
            else if (lookup_go)
                spec_ghr_q <= GHR_BITS'({spec_ghr_q, pht_rd_ctr[1]});
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_stat_branches <= '0;
            bp_stat_mispred  <= '0;
        end else if (retire_go) begin
            bp_stat_branches <= bp_stat_branches + 32'd1;
            if (rob_flush) bp_stat_mispred <= bp_stat_mispred + 32'd1;
        end
    end
`endif

    // Bits beyond the index are don't-care by definition.
    logic unused_bits;
    assign unused_bits = ^{fetch_bp_pc[29:IDX_BITS], pht_rd_ctr[0]};

    if (IDX_BITS < BPTAG_W) begin : g_tag_hi
        logic unused_tag_hi;
        assign unused_tag_hi = ^rob_ret_bptag[BPTAG_W-1:IDX_BITS];
    end

endmodule
